// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_entry_t  - one decoded-side buffer entry {instr, pc_plus4}
//   RESET_PC_DEFAULT, OP_MSB/OP_LSB (opcode slice used by decode), WORD_BYTES
//   word_align()   - clears the byte-offset bits of an address
package fetch_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          OP_MSB           = 31;
  localparam int          OP_LSB           = 26;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO used for both the instruction buffer and
// the in-order pc+4 tag queue of the fetch stage.
//   clk, reset  - clock / synchronous active-high reset (empties the FIFO)
//   push, din   - write din when push (dropped if full without a same-cycle pop)
//   pop, dout   - dout shows the head entry; pop removes it (ignored when empty)
//   flush       - empties the FIFO; same-cycle push/pop are discarded
//   count       - number of stored entries; full / empty status flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign count   = count_reg;
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  // Storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Keeps the PC, issues word reads over a valid/ready request channel, collects
// in-order responses into a small buffer and hands {instr, pc+4} to decode.
// Redirects from execute restart fetch at a new PC, flushing the buffer and
// discarding responses that are still in flight.
//   imem_req_valid/ready, imem_addr   - request channel (imem_addr = PC)
//   imem_rsp_valid, imem_rsp_data     - in-order responses, latency >= 1
//   redirect_valid, redirect_pc       - restart fetch (low two bits ignored)
//   id_valid/ready, id_instr, id_pc_plus4 - buffer head towards decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [31:0]      pc_reg;
  logic [31:0]      pc_next;
  logic [CNT_W-1:0] drop_reg;
  logic [CNT_W-1:0] drop_next;

  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] inflight_after;
  logic [CNT_W-1:0] buf_count;
  logic [OCC_W-1:0] occupancy;
  logic             tag_full;
  logic             tag_empty;
  logic             buf_full;
  logic             buf_empty;
  logic [31:0]      tag_head;
  fetch_entry_t     buf_din;
  fetch_entry_t     buf_head;
  logic             accept;
  logic             rsp_fire;
  logic             buf_push;
  logic             buf_pop;

  assign pc_plus4  = pc_reg + WORD_BYTES;
  // Buffered plus outstanding fetches never exceed the buffer size, so every
  // response has a guaranteed slot.
  assign occupancy = {1'b0, inflight} + {1'b0, buf_count};

  assign imem_req_valid = !reset && !redirect_valid && (occupancy < OCC_W'(BUF_DEPTH));
  assign imem_addr      = pc_reg;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response with no matching outstanding request (issued before a reset)
  // is ignored.
  assign rsp_fire = imem_rsp_valid && !tag_empty;
  assign buf_push = rsp_fire && (drop_reg == '0);
  assign buf_pop  = id_valid && id_ready;
  assign buf_din  = '{instr: imem_rsp_data, pc_plus4: tag_head};

  assign inflight_after = inflight + CNT_W'(accept) - CNT_W'(rsp_fire);

  assign id_valid    = !reset && !buf_empty;
  assign id_instr    = id_valid ? buf_head.instr    : '0;
  assign id_pc_plus4 = id_valid ? buf_head.pc_plus4 : '0;

  // The tag queue occupancy is the number of requests in flight; each entry
  // remembers pc+4 of its request so responses need not carry the address.
  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (32)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (rsp_fire),
    .flush (1'b0),
    .din   (pc_plus4),
    .dout  (tag_head),
    .count (inflight),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_fifo #(
    .DEPTH ($bits(fetch_entry_t) > 0 ? BUF_DEPTH : 1),
    .WIDTH ($bits(fetch_entry_t))
  ) u_buf_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .din   (buf_din),
    .dout  (buf_head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  always_comb begin
    pc_next   = pc_reg;
    drop_next = drop_reg;
    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      pc_next   = word_align(redirect_pc);
      drop_next = inflight_after;
    end else begin
      if (rsp_fire && (drop_reg != '0)) drop_next = drop_reg - 1'b1;
      if (accept) pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg   <= RESET_PC;
      drop_reg <= '0;
    end else begin
      pc_reg   <= pc_next;
      drop_reg <= drop_next;
    end
  end

  // The credit rule must make overflow of either queue impossible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(buf_push && !redirect_valid && buf_full && !buf_pop));
      assert (!(accept && tag_full && !rsp_fire));
    end
  end

endmodule
